// File: rtl/segasys1_sndlatch.sv
// -----------------------------------------------------------------------------
// segasys1_sndlatch
//
// Sound-side command receiver. The main CPU writes a sound command with the
// SNDRQ strobe and a data byte; this block stores the byte, presents it to the
// sound CPU on SNDNO and holds SNMI high while a command is pending. A command
// is retired when the sound CPU finishes reading the command address (falling
// edge of SCPURD). The block also produces the sound CPU's periodic maskable
// interrupt SIRQ from a free-running counter.
//
// Build option:
//   SEGASYS1_SNDLATCH_FIFO_EN defined   -> 4-entry circular command buffer
//   SEGASYS1_SNDLATCH_FIFO_EN undefined -> single command register
//
// Parameters:
//   IRQ_PERIOD  CLK48M cycles between SIRQ assertions
//   IRQ_WIDTH   CLK48M cycles SIRQ stays high per period (< IRQ_PERIOD)
//
// Ports:
//   CLK48M  in   system clock, rising edge
//   RESETn  in   synchronous reset, active low
//   SNDRQ   in   main-CPU sound-command write strobe (level)
//   MCPUDO  in   main-CPU data bus, captured on SNDRQ rising edge
//   SCPURD  in   sound-CPU read of the command address (level)
//   SNDNO   out  command byte presented to the sound CPU
//   SNMI    out  NMI request, high while a command is pending
//   SIRQ    out  periodic interrupt request
//   LEVEL   out  number of pending commands
//   OVF     out  sticky overrun flag
//
// Handshake: there is no ready path back to the main CPU. Every SNDRQ rising
// edge is a push; if storage is full (and nothing is leaving that same edge)
// the push is an overrun and OVF latches. Every SCPURD falling edge while
// LEVEL>0 is a pop; SNDNO is therefore stable for the whole read cycle.
// -----------------------------------------------------------------------------
module segasys1_sndlatch #(
  parameter int IRQ_PERIOD = 200000,
  parameter int IRQ_WIDTH  = 64
) (
  input  logic       CLK48M,
  input  logic       RESETn,
  input  logic       SNDRQ,
  input  logic [7:0] MCPUDO,
  input  logic       SCPURD,
  output logic [7:0] SNDNO,
  output logic       SNMI,
  output logic       SIRQ,
  output logic [2:0] LEVEL,
  output logic       OVF
);

`ifdef SEGASYS1_SNDLATCH_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  localparam int CW_RAW = $clog2(IRQ_PERIOD);
  localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;

  // ---------------------------------------------------------------------------
  // Edge detection on the two strobes
  // ---------------------------------------------------------------------------
  logic sq_q;
  logic rd_q;
  logic push;
  logic pop;
  logic full;

  // Pending-count and flag state common to both builds
  logic [2:0] level_q;
  logic [2:0] level_d;
  logic       snmi_q;
  logic       snmi_d;
  logic       ovf_q;
  logic       ovf_set;

  assign push = SNDRQ & ~sq_q;
  assign pop  = ~SCPURD & rd_q & (level_q != 3'd0);
  assign full = (level_q == 3'(DEPTH));

  // A push into full storage is only an overrun if no entry leaves the same
  // edge; with a simultaneous pop there is room for it.
  assign ovf_set = push & full & ~pop;

  always_ff @(posedge CLK48M) begin
    if (!RESETn) begin
      sq_q <= 1'b0;
      rd_q <= 1'b0;
    end else begin
      sq_q <= SNDRQ;
      rd_q <= SCPURD;
    end
  end

`ifdef SEGASYS1_SNDLATCH_FIFO_EN
  // ---------------------------------------------------------------------------
  // 4-entry circular buffer. Pointers are 2 bits and wrap naturally; LEVEL
  // disambiguates full from empty.
  // ---------------------------------------------------------------------------
  logic [7:0] mem_q [0:3];
  logic [1:0] wr_ptr_q;
  logic [1:0] wr_ptr_d;
  logic [1:0] rd_ptr_q;
  logic [1:0] rd_ptr_d;
  logic [7:0] sndno_q;
  logic [7:0] sndno_d;
  logic [7:0] head_d;
  logic       push_ok;

  always_comb begin
    push_ok  = push & (~full | pop);
    wr_ptr_d = wr_ptr_q + 2'(push_ok);
    rd_ptr_d = rd_ptr_q + 2'(pop);
    level_d  = level_q + 3'(push_ok) - 3'(pop);

    // The entry that will be at the head after this edge. If it is the slot
    // being written right now (storage empty, or its only entry leaving), the
    // memory does not hold it yet, so take the byte straight from the bus.
    if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
      head_d = MCPUDO;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end

    // With nothing pending, SNDNO keeps the last byte it showed.
    if (level_d != 3'd0) begin
      sndno_d = head_d;
    end else begin
      sndno_d = sndno_q;
    end
  end

  // Storage array has no reset: its contents are only visible through the
  // pointers, which are reset.
  always_ff @(posedge CLK48M) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= MCPUDO;
    end
  end

  always_ff @(posedge CLK48M) begin
    if (!RESETn) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      sndno_q  <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      sndno_q  <= sndno_d;
    end
  end

  assign SNDNO = sndno_q;

`else
  // ---------------------------------------------------------------------------
  // Single command register. A push always writes the register: into an
  // empty latch, as a replacement of the entry leaving this edge, or as an
  // overwrite of an unread command (which is the overrun case).
  // ---------------------------------------------------------------------------
  logic [7:0] data_q;
  logic [7:0] data_d;

  always_comb begin
    data_d = data_q;
    if (push) begin
      data_d = MCPUDO;
    end

    if (push || ((level_q != 3'd0) && !pop)) begin
      level_d = 3'd1;
    end else begin
      level_d = 3'd0;
    end
  end

  always_ff @(posedge CLK48M) begin
    if (!RESETn) begin
      data_q <= 8'h00;
    end else begin
      data_q <= data_d;
    end
  end

  // A pop never changes the register, so it naturally keeps the last byte.
  assign SNDNO = data_q;
`endif

  // ---------------------------------------------------------------------------
  // NMI request. Forcing SNMI low on the pop edge gives the edge-sensitive
  // NMI input a fresh rising edge one clock later if more commands remain.
  // Two pops cannot occur on consecutive edges (each needs SCPURD to rise
  // and fall again), so the low pulse is always exactly one clock.
  // An overwrite in the single build has no pop and so keeps SNMI high.
  // ---------------------------------------------------------------------------
  always_comb begin
    snmi_d = (level_d != 3'd0) & ~pop;
  end

  always_ff @(posedge CLK48M) begin
    if (!RESETn) begin
      level_q <= 3'd0;
      snmi_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      snmi_q  <= snmi_d;
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign LEVEL = level_q;
  assign SNMI  = snmi_q;
  assign OVF   = ovf_q;

  // ---------------------------------------------------------------------------
  // Periodic interrupt. SIRQ is registered from the counter value before it
  // advances, so the first high clock follows the first edge after reset
  // release (counter value 0).
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          sirq_q;
  logic          sirq_d;

  always_comb begin
    if (cnt_q == CW'(IRQ_PERIOD - 1)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    sirq_d = (cnt_q < CW'(IRQ_WIDTH));
  end

  always_ff @(posedge CLK48M) begin
    if (!RESETn) begin
      cnt_q  <= '0;
      sirq_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sirq_q <= sirq_d;
    end
  end

  assign SIRQ = sirq_q;

endmodule
